resposta_uart_tx: RTL and testbench



---
 rtl/resposta_uart_tx.sv | 139 +++++++++++++
 tb/tb_resposta_uart_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/resposta_uart_tx.sv
// UART transmitter for the sensor response pair: sends the command byte then the
// value byte as two back-to-back 8N1 frames, LSB first, with busy/done/overrun status.
module resposta_uart_tx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dadosPodemSerEnviados,
    input  logic [7:0] response_command,
    input  logic [7:0] response_value,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_n;
    logic              byte_sel, byte_sel_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_n;
    logic [7:0]        command_reg, command_reg_n;
    logic [7:0]        value_reg, value_reg_n;
    logic              tx_n, busy_n, done_n, overrun_n;

    logic [7:0] cur_byte;
    logic [2:0] next_idx;
    logic       baud_end;

    assign cur_byte = byte_sel ? value_reg : command_reg;
    assign next_idx = bit_idx + 3'd1;
    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            byte_sel    <= 1'b0;
            bit_idx     <= 3'd0;
            baud_cnt    <= '0;
            command_reg <= 8'd0;
            value_reg   <= 8'd0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            byte_sel    <= byte_sel_n;
            bit_idx     <= bit_idx_n;
            baud_cnt    <= baud_cnt_n;
            command_reg <= command_reg_n;
            value_reg   <= value_reg_n;
            tx          <= tx_n;
            busy        <= busy_n;
            done        <= done_n;
            overrun     <= overrun_n;
        end
    end

    // tx is computed from the state being entered so the line is a clean register output
    always_comb begin
        state_n       = state;
        byte_sel_n    = byte_sel;
        bit_idx_n     = bit_idx;
        baud_cnt_n    = baud_cnt;
        command_reg_n = command_reg;
        value_reg_n   = value_reg;
        tx_n          = tx;
        done_n        = 1'b0;
        overrun_n     = dadosPodemSerEnviados && (state != IDLE);

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (dadosPodemSerEnviados) begin
                    command_reg_n = response_command;
                    value_reg_n   = response_value;
                    byte_sel_n    = 1'b0;
                    baud_cnt_n    = '0;
                    state_n       = START;
                    tx_n          = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = 3'd0;
                    state_n    = DATA;
                    tx_n       = cur_byte[0];
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = next_idx;
                        tx_n      = cur_byte[next_idx];
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    if (!byte_sel) begin
                        byte_sel_n = 1'b1;
                        state_n    = START;
                        tx_n       = 1'b0;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        tx_n    = 1'b1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_resposta_uart_tx.sv
// Bench for resposta_uart_tx at 10 clocks per bit: table-driven directed transfers,
// random transfers against a frame-level line model, and an asynchronous mid-frame reset.
module tb_resposta_uart_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       dadosPodemSerEnviados = 1'b0;
    logic [7:0] response_command = 8'd0;
    logic [7:0] response_value = 8'd0;
    logic       tx, busy, done, overrun;

    int checks = 0;
    int errors = 0;

    resposta_uart_tx #(.CLK_FREQ(100), .BAUD_RATE(10)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .dadosPodemSerEnviados (dadosPodemSerEnviados),
        .response_command      (response_command),
        .response_value        (response_value),
        .tx                    (tx),
        .busy                  (busy),
        .done                  (done),
        .overrun               (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        int         gap;
        logic [7:0] cmd;
        logic [7:0] val;
        int         change_at;
        int         strobe2_at;
        logic [7:0] cmd2;
        logic [7:0] val2;
        logic [0:19] line;
    } vec_t;

    vec_t vectors[4];

    // Expected line for one transfer: start, command LSB first, stop, start, value LSB first, stop
    function automatic logic [0:19] model_line(input logic [7:0] c, input logic [7:0] v);
        logic [0:19] l;
        for (int i = 0; i < 20; i++) begin
            if (i == 0 || i == 10)       l[i] = 1'b0;
            else if (i == 9 || i == 19)  l[i] = 1'b1;
            else if (i < 9)              l[i] = c[i - 1];
            else                         l[i] = v[i - 11];
        end
        return l;
    endfunction

    task automatic check_output(input string tag, input string sig, input int n,
                                input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s %s cycle %0d: got %b expected %b", tag, sig, n, actual, expected);
        end
    endtask

    task automatic check_idle(input string tag, input int n);
        check_output(tag, "tx", n, tx, 1'b1);
        check_output(tag, "busy", n, busy, 1'b0);
        check_output(tag, "done", n, done, 1'b0);
        check_output(tag, "overrun", n, overrun, 1'b0);
    endtask

    task automatic idle_cycles(input string tag, input int count);
        for (int n = 1; n <= count; n++) begin
            @(posedge clock); #1;
            check_idle(tag, n);
        end
    endtask

    // Strobe in the current cycle, then check every cycle up to and including the done cycle.
    // Returns in the done cycle so a following call strobes exactly while done=1.
    task automatic apply_stimulus(input string tag, input logic [7:0] c, input logic [7:0] v,
                                  input logic [0:19] line, input int change_at,
                                  input int strobe2_at, input logic [7:0] c2, input logic [7:0] v2);
        response_command      = c;
        response_value        = v;
        dadosPodemSerEnviados = 1'b1;
        for (int n = 1; n <= 201; n++) begin
            @(posedge clock); #1;
            if (n <= 200) begin
                check_output(tag, "tx", n, tx, line[(n - 1) / 10]);
                check_output(tag, "busy", n, busy, 1'b1);
                check_output(tag, "done", n, done, 1'b0);
            end else begin
                check_output(tag, "tx", n, tx, 1'b1);
                check_output(tag, "busy", n, busy, 1'b0);
                check_output(tag, "done", n, done, 1'b1);
            end
            check_output(tag, "overrun", n, overrun, (strobe2_at > 0) && (n == strobe2_at + 1));
            dadosPodemSerEnviados = (n == strobe2_at);
            if (n == change_at || n == strobe2_at) begin
                response_command = c2;
                response_value   = v2;
            end
        end
    endtask

    initial begin
        vectors[0] = '{"basic",     5, 8'h09, 8'h1A, -1, -1, 8'h00, 8'h00, 20'b0100100001_0010110001};
        vectors[1] = '{"stability", 3, 8'h07, 8'h07, 30, -1, 8'hFF, 8'hFF, 20'b0111000001_0111000001};
        vectors[2] = '{"overrun",   2, 8'h08, 8'h2D, -1, 50, 8'h45, 8'h45, 20'b0000100001_0101101001};
        vectors[3] = '{"backtoback",0, 8'hAA, 8'hAA, -1, -1, 8'h00, 8'h00, 20'b0010101011_0010101011};

        for (int n = 1; n <= 5; n++) begin
            @(posedge clock); #1;
            check_idle("reset", n);
        end
        reset = 1'b1;
        idle_cycles("idle", 50);

        for (int i = 0; i < 4; i++) begin
            idle_cycles(vectors[i].name, vectors[i].gap);
            apply_stimulus(vectors[i].name, vectors[i].cmd, vectors[i].val, vectors[i].line,
                           vectors[i].change_at, vectors[i].strobe2_at,
                           vectors[i].cmd2, vectors[i].val2);
        end

        for (int r = 0; r < 6; r++) begin
            logic [7:0] rc, rv;
            rc = 8'($urandom);
            rv = 8'($urandom);
            idle_cycles("rand", $urandom_range(0, 3));
            apply_stimulus("rand", rc, rv, model_line(rc, rv), -1, -1, 8'h00, 8'h00);
        end

        // Abort a transfer while the value byte's data bits are on the line
        idle_cycles("midreset", 2);
        begin
            logic [0:19] l;
            l = model_line(8'h55, 8'h66);
            response_command      = 8'h55;
            response_value        = 8'h66;
            dadosPodemSerEnviados = 1'b1;
            for (int n = 1; n <= 130; n++) begin
                @(posedge clock); #1;
                dadosPodemSerEnviados = 1'b0;
                check_output("midreset", "tx", n, tx, l[(n - 1) / 10]);
                check_output("midreset", "busy", n, busy, 1'b1);
            end
        end
        reset = 1'b0;
        #1;
        check_idle("midreset_async", 130);
        for (int n = 1; n <= 3; n++) begin
            @(posedge clock); #1;
            check_idle("midreset_hold", n);
        end
        reset = 1'b1;
        idle_cycles("midreset_after", 250);
        apply_stimulus("postreset", 8'h01, 8'h02, 20'b0100000001_0010000001, -1, -1, 8'h00, 8'h00);
        idle_cycles("final", 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
